// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//
// Retire monitor placed after the CPU writeback stage. Every RUN cycle with a
// retire event (wb_valid | hlt) it builds a packed trace record and pushes it
// into an on-chip FIFO. It also keeps cycle, instruction and dropped-record
// counters. A consumer drains the FIFO through a valid/ready port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   arm                 pulse: clear counters and FIFO, enter RUN
//   wb_*, mem_*, hlt    retiring-instruction information from writeback
//   rd_valid/rd_ready   FIFO head handshake
//   rd_data[54:0]       {kind[1:0], is_load, reg[3:0], pc, val, addr}
//   level               FIFO occupancy (0..DEPTH)
//   cycle_count         RUN cycles since arm
//   inst_count          retire events since arm (pushed or dropped)
//   drop_count          records lost to a full FIFO, saturating
//   overflow            sticky, set on the first drop
//   halted              high while in the HALTED state
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     wb_valid,
    input  logic [15:0]              wb_pc,
    input  logic                     wb_regwrite,
    input  logic [3:0]               wb_dstreg,
    input  logic [15:0]              wb_dstdata,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [15:0]              mem_addr,
    input  logic [15:0]              mem_wdata,
    input  logic                     hlt,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [54:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         inst_count,
    output logic [15:0]              drop_count,
    output logic                     overflow,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]        level_reg;
    logic [CNT_W-1:0]   cycle_count_reg, inst_count_reg;
    logic [15:0]        drop_count_reg;
    logic               overflow_reg;
    logic [54:0]        mem [DEPTH];

    logic               retire_ev;
    logic               pop;
    logic               push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_nonempty;
    logic [54:0]        record;

    // arm overrides everything in its cycle: retire inputs and any pop are
    // ignored so the cleared FIFO starts truly empty.
    assign fifo_nonempty = (level_reg != '0);
    assign fifo_full     = (level_reg == FULL_LEVEL);
    assign retire_ev     = (state_reg == ST_RUN) & (wb_valid | hlt) & ~arm;
    assign pop           = fifo_nonempty & rd_ready & ~arm;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push          = retire_ev & (~fifo_full | pop);
    assign drop          = retire_ev & ~push;

    // Record kind in priority order: REG, HALT, STORE, NOP.
    always_comb begin
        record = '0;
        if (wb_regwrite && wb_valid) begin
            record = {2'd1, mem_read, wb_dstreg, wb_pc, wb_dstdata,
                      (mem_read ? mem_addr : 16'h0000)};
        end else if (hlt) begin
            record = {2'd3, 1'b0, 4'h0, wb_pc, 16'h0000, 16'h0000};
        end else if (mem_write) begin
            record = {2'd2, 1'b0, 4'h0, wb_pc, mem_wdata, mem_addr};
        end else begin
            record = {2'd0, 1'b0, 4'h0, wb_pc, 16'h0000, 16'h0000};
        end
    end

    always_comb begin
        state_next = state_reg;
        if (arm) begin
            state_next = ST_RUN;
        end else if (retire_ev && hlt) begin
            // Also covers a REG record with hlt set, and a dropped HALT.
            state_next = ST_HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            cycle_count_reg <= '0;
            inst_count_reg  <= '0;
            drop_count_reg  <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (arm) begin
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                level_reg       <= '0;
                cycle_count_reg <= '0;
                inst_count_reg  <= '0;
                drop_count_reg  <= '0;
                overflow_reg    <= 1'b0;
            end else begin
                if (state_reg == ST_RUN) begin
                    cycle_count_reg <= cycle_count_reg + CNT_W'(1);
                end
                if (retire_ev) begin
                    inst_count_reg <= inst_count_reg + CNT_W'(1);
                end
                if (drop) begin
                    overflow_reg <= 1'b1;
                    if (drop_count_reg != 16'hFFFF) begin
                        drop_count_reg <= drop_count_reg + 16'd1;
                    end
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level_reg <= level_reg + (AW+1)'(1);
                    2'b01:   level_reg <= level_reg - (AW+1)'(1);
                    default: level_reg <= level_reg;
                endcase
            end
        end
    end

    // Storage carries no reset; stale entries are masked by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= record;
        end
    end

    assign rd_valid    = fifo_nonempty;
    assign rd_data     = fifo_nonempty ? mem[rd_ptr_reg] : '0;
    assign level       = level_reg;
    assign cycle_count = cycle_count_reg;
    assign inst_count  = inst_count_reg;
    assign drop_count  = drop_count_reg;
    assign overflow    = overflow_reg;
    assign halted      = (state_reg == ST_HALTED);

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, arm, wb_valid, wb_regwrite, mem_read, mem_write, hlt, rd_ready;
    logic [15:0] wb_pc, wb_dstdata, mem_addr, mem_wdata;
    logic [3:0]  wb_dstreg;
    logic        rd_valid, overflow, halted;
    logic [54:0] rd_data;
    logic [4:0]  level;
    logic [31:0] cycle_count, inst_count;
    logic [15:0] drop_count;

    retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .arm(arm), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_regwrite(wb_regwrite), .wb_dstreg(wb_dstreg), .wb_dstdata(wb_dstdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .hlt(hlt), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .level(level), .cycle_count(cycle_count),
        .inst_count(inst_count), .drop_count(drop_count), .overflow(overflow),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state: trace queue, counters, mode (0 idle, 1 run, 2 halted).
    logic [54:0] m_q[$];
    logic [31:0] m_cyc, m_inst;
    logic [15:0] m_drop;
    logic        m_ovf;
    int          m_st;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [54:0] mk_rec();
        if (wb_regwrite && wb_valid)
            return {2'd1, mem_read, wb_dstreg, wb_pc, wb_dstdata, mem_read ? mem_addr : 16'h0};
        if (hlt)       return {2'd3, 1'b0, 4'h0, wb_pc, 32'h0};
        if (mem_write) return {2'd2, 1'b0, 4'h0, wb_pc, mem_wdata, mem_addr};
        return {2'd0, 1'b0, 4'h0, wb_pc, 32'h0};
    endfunction

    task automatic model_step();
        bit do_pop, do_ret, acc;
        logic [54:0] rec;
        if (rst || arm) begin
            m_q.delete();
            m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0;
            m_st = rst ? 0 : 1;
        end else begin
            do_pop = (m_q.size() > 0) && rd_ready;
            do_ret = (m_st == 1) && (wb_valid || hlt);
            acc = 0;
            rec = mk_rec();
            if (m_st == 1) m_cyc++;
            if (do_ret) begin
                m_inst++;
                if (m_q.size() < DEPTH || do_pop) acc = 1;
                else begin
                    if (m_drop != 16'hFFFF) m_drop++;
                    m_ovf = 1;
                end
                if (hlt) m_st = 2;
            end
            if (do_pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(rec);
        end
    endtask

    task automatic check_all();
        chk("rd_valid", rd_valid, m_q.size() != 0);
        chk("rd_data", rd_data, (m_q.size() != 0) ? m_q[0] : 55'h0);
        chk("level", level, m_q.size());
        chk("cycle_count", cycle_count, m_cyc);
        chk("inst_count", inst_count, m_inst);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("halted", halted, m_st == 2);
        $display("cyc t=%0t lvl=%0d valid=%0b data=%h inst=%0d drop=%0d halted=%0b",
                 $time, level, rd_valid, rd_data, inst_count, drop_count, halted);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_in();
        wb_valid = 0; wb_regwrite = 0; mem_read = 0; mem_write = 0; hlt = 0;
        wb_pc = 0; wb_dstreg = 0; wb_dstdata = 0; mem_addr = 0; mem_wdata = 0;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic [3:0] dst,
                          input logic [15:0] dd, input logic [15:0] pc, input logic mr,
                          input logic mw, input logic [15:0] ma, input logic [15:0] md,
                          input logic h);
        wb_valid = v; wb_regwrite = rw; wb_dstreg = dst; wb_dstdata = dd; wb_pc = pc;
        mem_read = mr; mem_write = mw; mem_addr = ma; mem_wdata = md; hlt = h;
    endtask

    task automatic do_arm();
        arm = 1; step(); arm = 0;
    endtask

    initial begin
        logic [54:0] exp1[3];
        logic [31:0] saved;
        exp1[0] = {2'd1, 1'b0, 4'd3, 16'h0000, 16'h00AA, 16'h0000};
        exp1[1] = {2'd2, 1'b0, 4'd0, 16'h0002, 16'h1234, 16'h0010};
        exp1[2] = {2'd1, 1'b1, 4'd5, 16'h0004, 16'h5555, 16'h0010};

        rst = 1; arm = 0; rd_ready = 0; idle_in();
        step(); step();
        chk("reset_level", level, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 0;
        step();

        // Three captures with the consumer stalled.
        do_arm();
        set_in(1, 1, 4'd3, 16'h00AA, 16'h0000, 0, 0, 16'h0, 16'h0, 0); step();
        set_in(1, 0, 4'd0, 16'h0000, 16'h0002, 0, 1, 16'h0010, 16'h1234, 0); step();
        set_in(1, 1, 4'd5, 16'h5555, 16'h0004, 1, 0, 16'h0010, 16'h0, 0); step();
        idle_in();
        chk("t1_level", level, 3);
        chk("t1_inst", inst_count, 3);
        rd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_drain", rd_data, exp1[i]);
            step();
        end
        rd_ready = 0;

        // Bubbles then halt.
        for (int i = 0; i < 4; i++) step();
        set_in(0, 0, 4'd0, 16'h0, 16'h0006, 0, 0, 16'h0, 16'h0, 1); step();
        idle_in();
        chk("halt_flag", halted, 1);
        chk("halt_inst", inst_count, 4);
        chk("halt_cycles", cycle_count, 11);
        chk("halt_rec", rd_data, {2'd3, 1'b0, 4'd0, 16'h0006, 32'h0});
        saved = cycle_count;
        for (int i = 0; i < 10; i++) step();
        chk("halt_frozen", cycle_count, saved);

        // Overflow: 20 retires into a 16-entry FIFO.
        do_arm();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 4'(i), 16'(i), 16'(2 * i), 0, 0, 16'h0, 16'h0, 0); step();
        end
        idle_in();
        chk("ovf_level", level, 16);
        chk("ovf_drop", drop_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_inst", inst_count, 20);
        chk("ovf_head_pc", rd_data[47:32], 16'h0000);

        // Full with a simultaneous pop.
        rd_ready = 1;
        set_in(1, 1, 4'd9, 16'hBEEF, 16'h0100, 0, 0, 16'h0, 16'h0, 0); step();
        idle_in();
        chk("fullpop_level", level, 16);
        chk("fullpop_drop", drop_count, 4);
        for (int i = 0; i < 16; i++) begin
            chk("fullpop_order", rd_data[47:32], (i < 15) ? 16'(2 * (i + 1)) : 16'h0100);
            step();
        end
        chk("fullpop_empty", level, 0);
        rd_ready = 0;

        // Re-arm while HALTED with five entries queued.
        do_arm();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 4'd1, 16'(i), 16'(16'h0200 + i), 0, 0, 16'h0, 16'h0, 0); step();
        end
        set_in(1, 0, 4'd0, 16'h0, 16'h0208, 0, 0, 16'h0, 16'h0, 1); step();
        idle_in();
        chk("rearm_pre_level", level, 5);
        chk("rearm_pre_halt", halted, 1);
        do_arm();
        chk("rearm_level", level, 0);
        chk("rearm_inst", inst_count, 0);
        chk("rearm_halted", halted, 0);
        set_in(1, 0, 4'd0, 16'h0, 16'h0300, 0, 1, 16'h0040, 16'h7777, 0); step();
        chk("rearm_run", level, 1);
        chk("rearm_cyc", cycle_count, 1);

        // Asynchronous reset between edges.
        set_in(1, 1, 4'd2, 16'h0002, 16'h0302, 0, 0, 16'h0, 16'h0, 0); step();
        idle_in();
        #2 rst = 1;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_level", level, 0);
        chk("arst_cyc", cycle_count, 0);
        chk("arst_inst", inst_count, 0);
        model_step();
        step();
        rst = 0;
        set_in(1, 1, 4'd4, 16'h0044, 16'h0400, 0, 0, 16'h0, 16'h0, 0); step();
        idle_in();
        chk("idle_ignored", level, 0);

        // Streaming: one push and one pop per cycle.
        do_arm();
        rd_ready = 1;
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0)
                set_in(1, 0, 4'd0, 16'h0, 16'(i * 2), 0, 1, 16'(i), 16'($urandom), 0);
            else
                set_in(1, 1, 4'(i), 16'($urandom), 16'(i * 2), i % 3 == 1, 0, 16'(i + 5), 16'h0, 0);
            step();
            chk("stream_level", level <= 1, 1);
        end
        idle_in();
        step();
        chk("stream_drop", drop_count, 0);
        chk("stream_inst", inst_count, 100);
        chk("stream_empty", level, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
